famicom_pad_reader: RTL and testbench

Initiator side of the Famicom/NES serial controller protocol. It drives latch and pulse to a physical controller wired to the user port, samples the serial data line, and presents a parallel, active-high 8-button word. It runs in the `clk_sys` domain. Its output feeds the joypad path in the `emu` top in place of, or OR'd with, the HPS joystick.

---
 rtl/famicom_pad_reader.sv | 172 +++++++++++++++++
 tb/tb_famicom_pad_reader.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/famicom_pad_reader.sv
`default_nettype none
// ============================================================================
// Module   : famicom_pad_reader
// Purpose  : Famicom/NES controller reader. It drives latch and pulse, samples
//            the serial line and presents an active-high 8-button word.
//            Optional macro: FAMICOM_READER_DEBOUNCE_EN (two-frame agreement).
// Revision : 1.0 - initial release
// ============================================================================
module famicom_pad_reader #(
    parameter int HALF_PERIOD = 300,
    parameter int POLL_PERIOD = 833333
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       poll_now,
    input  logic       pad_data,
    output logic       pad_latch,
    output logic       pad_pulse,
    output logic [7:0] buttons,
    output logic       buttons_valid,
    output logic       busy
);

    localparam int TW = $clog2(2 * HALF_PERIOD);
    localparam int PW = $clog2(POLL_PERIOD);
    localparam logic [TW-1:0] C_LATCH_LAST = TW'(2 * HALF_PERIOD - 1);
    localparam logic [TW-1:0] C_HALF_LAST  = TW'(HALF_PERIOD - 1);
    localparam logic [PW-1:0] C_POLL_LAST  = PW'(POLL_PERIOD - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LATCH = 3'd1,
        S_WAIT0 = 3'd2,
        S_PHI   = 3'd3,
        S_PLO   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic          sync1_q, sync2_q;
    logic [PW-1:0] poll_cnt_q, poll_cnt_d;
    logic          start_q, start_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    buttons_q, buttons_d;
`ifdef FAMICOM_READER_DEBOUNCE_EN
    logic [7:0]    raw_q, raw_d;
`endif

    logic w_wrap;
    logic w_sample;

    assign w_wrap   = (poll_cnt_q == C_POLL_LAST);
    assign w_sample = ~sync2_q;
    assign buttons  = buttons_q;

    // Requests are registered only in IDLE, so anything arriving while a
    // frame is running (or one is already pending) is simply dropped.
    assign start_d    = (w_wrap | poll_now) & (state_q == S_IDLE) & ~start_q;
    assign poll_cnt_d = w_wrap ? '0 : poll_cnt_q + 1'b1;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            poll_cnt_q <= '0;
            start_q    <= 1'b0;
            state_q    <= S_IDLE;
            tmr_q      <= '0;
            idx_q      <= 3'd0;
            shift_q    <= 8'h00;
            buttons_q  <= 8'h00;
`ifdef FAMICOM_READER_DEBOUNCE_EN
            raw_q      <= 8'h00;
`endif
        end else begin
            sync1_q    <= pad_data;
            sync2_q    <= sync1_q;
            poll_cnt_q <= poll_cnt_d;
            start_q    <= start_d;
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            buttons_q  <= buttons_d;
`ifdef FAMICOM_READER_DEBOUNCE_EN
            raw_q      <= raw_d;
`endif
        end
    end

    always_comb begin
        state_d       = state_q;
        tmr_d         = tmr_q + 1'b1;
        idx_d         = idx_q;
        shift_d       = shift_q;
        buttons_d     = buttons_q;
`ifdef FAMICOM_READER_DEBOUNCE_EN
        raw_d         = raw_q;
`endif
        pad_latch     = 1'b0;
        pad_pulse     = 1'b0;
        buttons_valid = 1'b0;
        busy          = 1'b1;

        case (state_q)
            S_IDLE: begin
                busy  = 1'b0;
                tmr_d = '0;
                if (start_q) begin
                    state_d = S_LATCH;
                end
            end
            S_LATCH: begin
                pad_latch = 1'b1;
                if (tmr_q == C_LATCH_LAST) begin
                    tmr_d   = '0;
                    state_d = S_WAIT0;
                end
            end
            S_WAIT0: begin
                if (tmr_q == C_HALF_LAST) begin
                    tmr_d      = '0;
                    shift_d[0] = w_sample;
                    idx_d      = 3'd1;
                    state_d    = S_PHI;
                end
            end
            S_PHI: begin
                pad_pulse = 1'b1;
                if (tmr_q == C_HALF_LAST) begin
                    tmr_d   = '0;
                    state_d = S_PLO;
                end
            end
            S_PLO: begin
                if (tmr_q == C_HALF_LAST) begin
                    tmr_d          = '0;
                    shift_d[idx_q] = w_sample;
                    if (idx_q == 3'd7) begin
                        // The word is committed on the edge entering DONE so
                        // that buttons and buttons_valid change together.
`ifdef FAMICOM_READER_DEBOUNCE_EN
                        raw_d = shift_d;
                        if (shift_d == raw_q) begin
                            buttons_d = shift_d;
                        end
`else
                        buttons_d = shift_d;
`endif
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = S_PHI;
                    end
                end
            end
            S_DONE: begin
                buttons_valid = 1'b1;
                tmr_d         = '0;
                state_d       = S_IDLE;
            end
            default: begin
                tmr_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_famicom_pad_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_famicom_pad_reader
// Purpose  : Self-checking bench for famicom_pad_reader with a controller model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_famicom_pad_reader;

    localparam int H     = 4;
    localparam int P     = 200;
    localparam int FRAME = 17 * H;

    logic       clk_sys  = 1'b0;
    logic       reset_n  = 1'b0;
    logic       poll_now = 1'b0;
    logic       pad_data;
    logic       pad_latch;
    logic       pad_pulse;
    logic [7:0] buttons;
    logic       buttons_valid;
    logic       busy;

    always #5 clk_sys = ~clk_sys;

    famicom_pad_reader #(
        .HALF_PERIOD(H),
        .POLL_PERIOD(P)
    ) dut (
        .clk_sys      (clk_sys),
        .reset_n      (reset_n),
        .poll_now     (poll_now),
        .pad_data     (pad_data),
        .pad_latch    (pad_latch),
        .pad_pulse    (pad_pulse),
        .buttons      (buttons),
        .buttons_valid(buttons_valid),
        .busy         (busy)
    );

    // Controller: reloads while latched, shifts on each rising pulse, 0 = pressed.
    logic [7:0] ctrl_word = 8'h00;
    logic       line_open = 1'b0;
    logic [7:0] cur_exp   = 8'h00;
    logic [7:0] ctrl_sh   = 8'hFF;
    logic       ctrl_pp   = 1'b0;

    always @(posedge clk_sys) begin
        if (pad_latch)
            ctrl_sh <= ~ctrl_word;
        else if (pad_pulse && !ctrl_pp)
            ctrl_sh <= {1'b1, ctrl_sh[7:1]};
        ctrl_pp <= pad_pulse;
    end

    assign pad_data = line_open ? 1'b1 : ctrl_sh[0];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic       lat_prev = 1'b0, pul_prev = 1'b0, val_prev = 1'b0;
    int         t_latch = -1, pulse_cnt = 0, pulse_w = 0, latch_edges = 0;
    logic [7:0] cap_exp = 8'h00, m_btn = 8'h00, m_prev = 8'h00;

    typedef struct {
        logic [7:0] word;
        logic       open;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl [8];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic mon_reset();
        lat_prev  = 1'b0;
        pul_prev  = 1'b0;
        val_prev  = 1'b0;
        pulse_cnt = 0;
        pulse_w   = 0;
        m_btn     = 8'h00;
        m_prev    = 8'h00;
    endtask

    // One clock: advance to the falling edge, then audit the protocol.
    task automatic tick();
        @(negedge clk_sys);
        cyc++;
        check("latch_pulse_overlap", int'(pad_latch & pad_pulse), 0);
        if (pad_latch && !lat_prev) begin
            t_latch   = cyc;
            pulse_cnt = 0;
            cap_exp   = line_open ? 8'h00 : cur_exp;
            latch_edges++;
            check("busy_at_latch", busy, 1);
        end
        if (pad_pulse && !pul_prev) begin
            pulse_cnt++;
            pulse_w = 0;
        end
        if (pad_pulse) pulse_w++;
        if (!pad_pulse && pul_prev) check("pulse_width", pulse_w, H);
        if (val_prev) check("busy_after_valid", busy, 0);
        if (buttons_valid) begin
            check("valid_latency", cyc - t_latch, FRAME);
            check("pulse_count", pulse_cnt, 7);
            check("busy_at_valid", busy, 1);
`ifdef FAMICOM_READER_DEBOUNCE_EN
            if (cap_exp == m_prev) m_btn = cap_exp;
            m_prev = cap_exp;
`else
            m_btn = cap_exp;
`endif
            check("buttons", buttons, m_btn);
        end
        lat_prev = pad_latch;
        pul_prev = pad_pulse;
        val_prev = buttons_valid;
    endtask

    task automatic run_to(input int target);
        while (cyc < target) tick();
    endtask

    task automatic wait_valid(input int bound);
        int n = 0;
        while (!buttons_valid && n < bound) begin
            tick();
            n++;
        end
        check("valid_seen", buttons_valid, 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        check("idle_reached", busy, 0);
    endtask

    task automatic apply_frame(input logic [7:0] w, input logic op, input logic [7:0] e);
        wait_idle();
        ctrl_word = w;
        line_open = op;
        cur_exp   = e;
        poll_now  = 1'b1;
        tick();
        poll_now  = 1'b0;
        wait_valid(FRAME + 40);
    endtask

    initial begin
        int e0;
        int n;
        logic [7:0] rw;

        tbl[0] = '{word: 8'h89, open: 1'b0, exp: 8'h89};
        tbl[1] = '{word: 8'h00, open: 1'b0, exp: 8'h00};
        tbl[2] = '{word: 8'hFF, open: 1'b0, exp: 8'hFF};
        tbl[3] = '{word: 8'h5A, open: 1'b1, exp: 8'h00};
        tbl[4] = '{word: 8'h01, open: 1'b0, exp: 8'h01};
        tbl[5] = '{word: 8'h03, open: 1'b0, exp: 8'h03};
        tbl[6] = '{word: 8'h03, open: 1'b0, exp: 8'h03};
        tbl[7] = '{word: 8'h80, open: 1'b0, exp: 8'h80};

        // Reset state, then the first automatic poll.
        ctrl_word = 8'h89;
        cur_exp   = 8'h89;
        repeat (3) tick();
        check("rst_latch", pad_latch, 0);
        check("rst_pulse", pad_pulse, 0);
        check("rst_buttons", buttons, 0);
        check("rst_valid", buttons_valid, 0);
        check("rst_busy", busy, 0);
        reset_n = 1'b1;
        cyc     = 0;
        tick();
        check("post_rst_busy", busy, 0);
        check("post_rst_latch", pad_latch, 0);
        while (latch_edges == 0 && cyc < P + 60) tick();
        check("first_latch_cycle", t_latch, P + 1);
        wait_valid(FRAME + 10);

        // poll_now while idle: latch one cycle after the request is taken.
        ctrl_word = 8'h12;
        cur_exp   = 8'h12;
        run_to(280);
        poll_now = 1'b1;
        tick();
        poll_now = 1'b0;
        check("poll_latch_early", pad_latch, 0);
        tick();
        check("poll_latch_rise", pad_latch, 1);

        // poll_now mid-frame is dropped.
        run_to(300);
        e0 = latch_edges;
        poll_now = 1'b1;
        tick();
        poll_now = 1'b0;
        run_to(395);
        check("midframe_poll_dropped", latch_edges, e0);

        // poll_now coincident with the wrap yields a single frame.
        ctrl_word = 8'h24;
        cur_exp   = 8'h24;
        run_to(2 * P - 1);
        poll_now = 1'b1;
        tick();
        poll_now = 1'b0;
        e0 = latch_edges;
        run_to(520);
        check("wrap_poll_frames", latch_edges, e0 + 1);
        check("wrap_poll_latch_cycle", t_latch, 2 * P + 1);

        // Open line decodes as nothing pressed.
        apply_frame(8'hC3, 1'b1, 8'h00);

        for (int i = 0; i < 8; i++) apply_frame(tbl[i].word, tbl[i].open, tbl[i].exp);

        for (int i = 0; i < 8; i++) begin
            rw = 8'($urandom_range(0, 255));
            apply_frame(rw, 1'b0, rw);
        end

        // Asynchronous reset during the fourth pulse.
        wait_idle();
        ctrl_word = 8'h3C;
        cur_exp   = 8'h3C;
        poll_now  = 1'b1;
        tick();
        poll_now  = 1'b0;
        n = 0;
        while (!(pulse_cnt == 4 && pad_pulse) && n < FRAME + 40) begin
            tick();
            n++;
        end
        check("reach_bit4_pulse", pulse_cnt, 4);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_pulse", pad_pulse, 0);
        check("async_rst_latch", pad_latch, 0);
        check("async_rst_buttons", buttons, 0);
        check("async_rst_busy", busy, 0);
        mon_reset();
        repeat (4) tick();
        check("held_rst_pulse", pad_pulse, 0);
        reset_n = 1'b1;
        apply_frame(8'hA5, 1'b0, 8'hA5);
        apply_frame(8'hA5, 1'b0, 8'hA5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
